// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } forward_sel_t;

    typedef enum logic {
        StIdle,
        StWait
    } mem_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // x0 is hardwired to zero, so it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// ALU operand bypass select for a single execute-stage source register.
module forward_unit
    import hazard_pkg::*;
(
    input  logic         en_i,
    input  logic [4:0]   rs_i,
    input  logic [4:0]   rd_m_i,
    input  logic         reg_write_m_i,
    input  logic [4:0]   rd_w_i,
    input  logic         reg_write_w_i,
    output forward_sel_t fwd_o
);

    always_comb begin
        fwd_o = FWD_NONE;
        if (en_i) begin
            // Memory stage holds the younger result, so it wins over writeback.
            if (reg_write_m_i && reg_match(rs_i, rd_m_i)) begin
                fwd_o = FWD_M;
            end else if (reg_write_w_i && reg_match(rs_i, rd_w_i)) begin
                fwd_o = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use/branch handling, forwarding, DMEM wait FSM.
// Define HAZARD_FORWARDING_EN to enable bypassing; otherwise RAW hazards stall.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic [1:0]           ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 MemReadM,
    input  logic                 MemWriteM,
    input  logic                 DmemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 MemErr,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    mem_state_t           state_q, state_d;
    logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
    logic                 mem_err_q, mem_err_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic         mem_access, timeout, freeze, load_use, raw_stall, fwd_en;
    logic         stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    forward_sel_t fwd_a, fwd_b;

    assign mem_access = MemReadM | MemWriteM;
    assign timeout    = (state_q == StWait) & ~DmemReadyM & (wait_cnt_q == WaitLast);
    assign freeze     = ((state_q == StIdle) & mem_access & ~DmemReadyM) |
                        ((state_q == StWait) & ~DmemReadyM & ~timeout);
    assign load_use   = (ResultSrcE == RESULT_SRC_LOAD) &
                        (reg_match(Rs1D, RdE) | reg_match(Rs2D, RdE));

`ifdef HAZARD_FORWARDING_EN
    assign fwd_en    = 1'b1;
    assign raw_stall = 1'b0;
`else
    // Without bypassing, any in-flight E/M writer of a decode source must stall;
    // the register file is write-first, so the W stage is already visible.
    assign fwd_en    = 1'b0;
    assign raw_stall = (RegWriteE & (reg_match(Rs1D, RdE) | reg_match(Rs2D, RdE))) |
                       (RegWriteM & (reg_match(Rs1D, RdM) | reg_match(Rs2D, RdM)));
`endif

    forward_unit u_fwd_a (
        .en_i          (fwd_en),
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    forward_unit u_fwd_b (
        .en_i          (fwd_en),
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            StIdle: begin
                if (mem_access && !DmemReadyM) begin
                    state_d    = StWait;
                    wait_cnt_d = '0;
                end
            end
            StWait: begin
                if (DmemReadyM) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    state_d   = StIdle;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        stall_cnt_d = (stall_f && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // Priority: memory freeze, then branch redirect, then data hazard stall.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use || raw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign StallF     = stall_f;
    assign StallD     = stall_d;
    assign StallE     = stall_e;
    assign StallM     = stall_m;
    assign FlushD     = flush_d;
    assign FlushE     = flush_e;
    assign FlushW     = flush_w;
    assign ForwardAE  = fwd_a;
    assign ForwardBE  = fwd_b;
    assign MemErr     = mem_err_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MEM_TIMEOUT=4, CNT_WIDTH=4).
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, PCSrcE, MemReadM, MemWriteM, DmemReadyM;
    logic [1:0] ResultSrcE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [3:0] StallCount;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FwdOn = 1'b1;
`else
    localparam bit FwdOn = 1'b0;
`endif

    hazard_controller #(
        .MEM_TIMEOUT (4),
        .CNT_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .DmemReadyM (DmemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemErr     (MemErr),
        .StallCount (StallCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
        PCSrcE = 0; MemReadM = 0; MemWriteM = 0; DmemReadyM = 1;
    endtask

    // Advance one clock, leaving time 1 unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
    function automatic logic [6:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_ctl", ctl(), 7'b0000000);
        check("reset_cnt", StallCount, 0);
        check("reset_err", MemErr, 0);
        check("reset_fwd", {ForwardAE, ForwardBE}, 4'b0000);

        // Load-use on Rs1D.
        RdE = 5; ResultSrcE = 2'b01; Rs1D = 5;
        #1;
        check("ldu_ctl", ctl(), 7'b1100010);
        check("ldu_cnt_before", StallCount, 0);
        tick();
        check("ldu_cnt_after", StallCount, 1);
        idle_inputs();
        #1;
        check("idle_ctl", ctl(), 7'b0000000);
        tick();
        check("idle_cnt_hold", StallCount, 1);

        // Load-use on Rs2D, x0 immunity, non-load producer.
        RdE = 9; ResultSrcE = 2'b01; Rs2D = 9;
        #1;
        check("ldu_rs2", StallF, 1);
        RdE = 0; Rs2D = 0; Rs1D = 0;
        #1;
        check("ldu_x0", StallF, 0);
        RdE = 5; Rs1D = 5; ResultSrcE = 2'b00; RegWriteE = 0;
        #1;
        check("non_load", StallF, 0);
        idle_inputs();

        // Forwarding selects.
        RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7;
        #1;
        check("fwd_a_m", ForwardAE, FwdOn ? 2'b10 : 2'b00);
        check("fwd_b_none", ForwardBE, 2'b00);
        RdM = 0;
        #1;
        check("fwd_a_w", ForwardAE, FwdOn ? 2'b01 : 2'b00);
        RdM = 7; RegWriteM = 0; Rs2E = 7; Rs1E = 0;
        #1;
        check("fwd_b_w", {ForwardAE, ForwardBE}, FwdOn ? 4'b0001 : 4'b0000);
        RdW = 0;
        #1;
        check("fwd_b_x0", ForwardBE, 2'b00);
        idle_inputs();

        // Branch overrides load-use.
        PCSrcE = 1; RdE = 5; ResultSrcE = 2'b01; Rs1D = 5;
        #1;
        check("branch_ctl", ctl(), 7'b0000110);
        tick();
        check("branch_cnt", StallCount, 1);
        idle_inputs();

        // DMEM read stalls three cycles, completes on the fourth; freeze beats branch.
        MemReadM = 1; DmemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rd_freeze", ctl(), 7'b1111001);
            tick();
        end
        DmemReadyM = 1;
        #1;
        check("rd_release", ctl(), 7'b0000110);
        tick();
        check("rd_cnt", StallCount, 4);
        check("rd_err", MemErr, 0);
        idle_inputs();
        tick();

        // DMEM write never completes: 4 freeze cycles then timeout.
        MemWriteM = 1; DmemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wr_freeze", ctl(), 7'b1111001);
            tick();
        end
        #1;
        check("wr_timeout_ctl", ctl(), 7'b0000000);
        check("wr_err_before", MemErr, 0);
        tick();
        check("wr_err_set", MemErr, 1);
        check("wr_cnt", StallCount, 8);
        idle_inputs();
        tick();
        tick();
        check("wr_err_sticky", MemErr, 1);

        // Saturate the 4-bit stall counter.
        RdE = 3; ResultSrcE = 2'b01; Rs1D = 3;
        for (int i = 0; i < 10; i++) tick();
        check("cnt_saturate", StallCount, 15);
        idle_inputs();

        // RAW stall without forwarding.
        RegWriteM = 1; RdM = 3; Rs2D = 3;
        #1;
        check("raw_m_stall", StallF, FwdOn ? 1'b0 : 1'b1);
        check("raw_m_fwd_b", ForwardBE, 2'b00);
        RegWriteM = 0;
        #1;
        check("raw_m_nowrite", StallF, 0);
        idle_inputs();
        RegWriteE = 1; RdE = 4; Rs1D = 4;
        #1;
        check("raw_e_stall", ctl(), FwdOn ? 7'b0000000 : 7'b1100010);
        idle_inputs();

        // Reset clears sticky error and counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_err", MemErr, 0);
        check("rst_cnt", StallCount, 0);

        // Reset during a pending access abandons it.
        MemReadM = 1; DmemReadyM = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rst_wait_ctl", ctl(), 7'b0000000);
        check("rst_wait_cnt", StallCount, 0);
        tick();
        check("rst_wait_cnt2", StallCount, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
